// File: rtl/score_event_scheduler.sv
// score_event_scheduler
// Keeps a pending-points tally per requester, arbitrates round-robin and
// emits one single-cycle counterEnable pulse per owed point while the score
// counter reports ready.
// Optional feature macro: SCORE_SCHED_BURST_EN -- when defined, a granted
// requester is drained completely before the next arbitration; otherwise one
// point is issued per grant so concurrent requesters interleave.
module score_event_scheduler #(
  parameter int REQUESTERS    = 4,
  parameter int POINTS_WIDTH  = 4,
  parameter int PENDING_WIDTH = 8
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [REQUESTERS-1:0]              request,
  input  logic [REQUESTERS*POINTS_WIDTH-1:0] points,
  output logic [REQUESTERS-1:0]              accept,
  input  logic                               counterReady,
  output logic                               counterEnable,
  output logic [REQUESTERS-1:0]              grant,
  output logic                               busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, PULSE, HOLD} state_t;

  // Two guard bits so pending + points never wraps before the saturation test.
  localparam int SUM_W = ((PENDING_WIDTH > POINTS_WIDTH) ? PENDING_WIDTH : POINTS_WIDTH) + 2;
  localparam int IDX_W = $clog2(REQUESTERS);
  localparam logic [SUM_W-1:0] TALLY_MAX = {{(SUM_W-PENDING_WIDTH){1'b0}}, {PENDING_WIDTH{1'b1}}};

  state_t                   state_q, state_d;
  logic [PENDING_WIDTH-1:0] pend_q [REQUESTERS];
  logic [PENDING_WIDTH-1:0] pend_d [REQUESTERS];
  logic [SUM_W-1:0]         net_sum [REQUESTERS];
  logic [REQUESTERS-1:0]    dec;
  logic [IDX_W-1:0]         ptr_q, ptr_d;
  logic [IDX_W-1:0]         win_idx, gnt_idx, gnt_next_idx;
  logic                     win_found, any_pend_d;
  logic [REQUESTERS-1:0]    grant_q, grant_d;
  logic                     en_q, en_d;
  logic                     busy_q, busy_d;
`ifdef SCORE_SCHED_BURST_EN
  logic                     gnt_pend_nz;
`endif

  // Tally update: net of new post and the granted decrement, saturation on the net value.
  always_comb begin
    for (int i = 0; i < REQUESTERS; i++) begin
      dec[i]     = (state_q == PULSE) && grant_q[i];
      net_sum[i] = SUM_W'(pend_q[i]) + SUM_W'(points[i*POINTS_WIDTH +: POINTS_WIDTH])
                   - SUM_W'(dec[i]);
      accept[i]  = request[i] && (net_sum[i] <= TALLY_MAX);
      pend_d[i]  = accept[i] ? net_sum[i][PENDING_WIDTH-1:0]
                             : pend_q[i] - PENDING_WIDTH'(dec[i]);
    end
  end

  // Round-robin search from the pointer, plus index of the current grant.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int off = 0; off < REQUESTERS; off++) begin
      if (!win_found && (pend_q[(int'(ptr_q) + off) % REQUESTERS] != '0)) begin
        win_found = 1'b1;
        win_idx   = IDX_W'((int'(ptr_q) + off) % REQUESTERS);
      end
    end
    gnt_idx = '0;
    for (int i = 0; i < REQUESTERS; i++) begin
      if (grant_q[i]) gnt_idx = IDX_W'(i);
    end
    gnt_next_idx = (int'(gnt_idx) == REQUESTERS - 1) ? '0 : gnt_idx + IDX_W'(1);
    any_pend_d = 1'b0;
    for (int i = 0; i < REQUESTERS; i++) begin
      any_pend_d = any_pend_d | (pend_d[i] != '0);
    end
`ifdef SCORE_SCHED_BURST_EN
    gnt_pend_nz = (pend_q[gnt_idx] != '0);
`endif
  end

  // Sequencer next-state: grant, pulse while ready, guard cycle, release.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    en_d    = 1'b0;
    case (state_q)
      IDLE: begin
        grant_d = '0;
        if (win_found) begin
          grant_d = REQUESTERS'(1) << win_idx;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (counterReady) begin
          en_d    = 1'b1;
          state_d = PULSE;
        end
      end
      PULSE: state_d = HOLD;
      HOLD: begin
`ifdef SCORE_SCHED_BURST_EN
        if (gnt_pend_nz) begin
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = gnt_next_idx;
        end
`else
        state_d = IDLE;
        grant_d = '0;
        ptr_d   = gnt_next_idx;
`endif
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
    busy_d = any_pend_d || (state_d != IDLE);
  end

  // All state registers; reset clears everything at once, even mid-pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      for (int i = 0; i < REQUESTERS; i++) pend_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      for (int i = 0; i < REQUESTERS; i++) pend_q[i] <= pend_d[i];
    end
  end

  assign counterEnable = en_q;
  assign grant         = grant_q;
  assign busy          = busy_q;

endmodule
